// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle,
// result = {remainder, quotient}, abortable by annul or by dropping start.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t          state_q, state_nx;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic [W-1:0]    dvd_q, dvd_nx;
  logic [W-1:0]    dsr_q, dsr_nx;
  logic [W-1:0]    rem_q, rem_nx;
  logic            neg_dvd_q, neg_dvd_nx;
  logic            neg_dsr_q, neg_dsr_nx;
  logic [2*W-1:0]  result_q, result_nx;
  logic            ready_q, ready_nx;

  logic            op1_neg, op2_neg;
  logic [W-1:0]    op1_mag, op2_mag;
  logic [W:0]      r33, diff;
  logic            ge;
  logic [W-1:0]    quo_fix, rem_fix;

  // Operand magnitudes; negative flags are only ever set for signed divides
  assign op1_neg = signed_div_i & opdata1_i[W-1];
  assign op2_neg = signed_div_i & opdata2_i[W-1];
  assign op1_mag = op1_neg ? (~opdata1_i + W'(1)) : opdata1_i;
  assign op2_mag = op2_neg ? (~opdata2_i + W'(1)) : opdata2_i;

  // One restoring step: the shift register feeds dividend bits out of its MSB
  // and collects quotient bits in its LSB
  assign r33  = {rem_q, dvd_q[W-1]};
  assign diff = r33 - {1'b0, dsr_q};
  assign ge   = ~diff[W];

  assign quo_fix = (neg_dvd_q ^ neg_dsr_q) ? (~dvd_q + W'(1)) : dvd_q;
  assign rem_fix = neg_dvd_q ? (~rem_q + W'(1)) : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_dsr_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      dvd_q     <= dvd_nx;
      dsr_q     <= dsr_nx;
      rem_q     <= rem_nx;
      neg_dvd_q <= neg_dvd_nx;
      neg_dsr_q <= neg_dsr_nx;
      result_q  <= result_nx;
      ready_q   <= ready_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i)
          state_nx = (opdata2_i == '0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: state_nx = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i || !start_i)    state_nx = S_FREE;
        else if (cnt_q == CW'(W))   state_nx = S_END;
      end
      S_END: begin
        if (!start_i) state_nx = S_FREE;
      end
      default: state_nx = S_FREE;
    endcase
  end

  // Next values of the datapath and the registered outputs
  always_comb begin
    cnt_nx     = cnt_q;
    dvd_nx     = dvd_q;
    dsr_nx     = dsr_q;
    rem_nx     = rem_q;
    neg_dvd_nx = neg_dvd_q;
    neg_dsr_nx = neg_dsr_q;
    result_nx  = result_q;
    ready_nx   = ready_q;
    case (state_q)
      S_FREE: begin
        result_nx = '0;
        ready_nx  = 1'b0;
        if (start_i && !annul_i) begin
          neg_dvd_nx = op1_neg;
          neg_dsr_nx = op2_neg;
          dvd_nx     = op1_mag;
          dsr_nx     = op2_mag;
          rem_nx     = '0;
          cnt_nx     = '0;
        end
      end
      S_BYZERO: begin
        result_nx = '0;
        ready_nx  = !annul_i;
      end
      S_ON: begin
        if (annul_i || !start_i) begin
          cnt_nx    = '0;
          dvd_nx    = '0;
          dsr_nx    = '0;
          rem_nx    = '0;
          result_nx = '0;
          ready_nx  = 1'b0;
        end else if (cnt_q == CW'(W)) begin
          result_nx = {rem_fix, quo_fix};
          ready_nx  = 1'b1;
        end else begin
          rem_nx = ge ? diff[W-1:0] : r33[W-1:0];
          dvd_nx = {dvd_q[W-2:0], ge};
          cnt_nx = cnt_q + CW'(1);
        end
      end
      S_END: begin
        if (!start_i) begin
          result_nx = '0;
          ready_nx  = 1'b0;
        end
      end
      default: begin
        result_nx = '0;
        ready_nx  = 1'b0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares on each rising ready_o.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result_o;
  logic        ready_o;

  logic [63:0] exp_q[$];
  logic        ready_prev;
  int          checks = 0;
  int          errors = 0;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;

  // Monitor: result must be 0 when not ready; each new result matches the queue head
  initial ready_prev = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!ready_o) begin
      checks++;
      if (result_o != 64'd0) begin
        errors++;
        $display("FAIL idle_result: got %h want 0", result_o);
      end
    end
    if (ready_o && !ready_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %h with no pending request", result_o);
      end else begin
        e = exp_q.pop_front();
        if (result_o != e) begin
          errors++;
          $display("FAIL result: got %h want %h", result_o, e);
        end
      end
    end
    ready_prev <= ready_o;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    annul      = 1'b0;
    start      = 1'b1;
  endtask

  // Edge index (E0 = accepting edge) at which ready_o is first seen high
  task automatic wait_ready(input int lat);
    int n;
    n = -1;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", n, lat);
    end
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input int lat);
    issue(sgn, a, b);
    exp_q.push_back(e);
    wait_ready(lat);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, e);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", 64'(ready_o), 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  initial begin
    rst        = 1'b0;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 33);
    run_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);
    run_div(1'b0, 32'd123, 32'd0, 64'd0, 1);

    // Annul in ON at cnt=10, then an immediate new divide
    issue(1'b0, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Dropping start mid-divide aborts as well
    issue(1'b0, 32'd50, 32'd5);
    repeat (6) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 64'(ready_o), 64'd0);
    run_div(1'b0, 32'd49, 32'd5, {32'd4, 32'd9}, 33);

    // Asynchronous reset mid-divide at cnt=20
    issue(1'b0, 32'd100, 32'd7);
    repeat (21) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    run_div(1'b0, 32'd1, 32'd1, {32'd0, 32'd1}, 33);

    // Asynchronous reset while holding a result in END clears outputs at once
    issue(1'b0, 32'd100, 32'd7);
    exp_q.push_back({32'd2, 32'd14});
    wait_ready(33);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'h3}, 33);

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
